// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_seq_pkg
// Desc   : Shared ALU select codes, command encodings and sequencer states.
// Rev    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam logic [3:0] c_sel_nop = 4'b0000;
    localparam logic [3:0] c_sel_add = 4'b0001;
    localparam logic [3:0] c_sel_sub = 4'b0010;
    localparam logic [3:0] c_sel_nor = 4'b0011;
    localparam logic [3:0] c_sel_eq  = 4'b0110;
    localparam logic [3:0] c_sel_lt  = 4'b1000;
    localparam logic [3:0] c_sel_shl = 4'b1011;
    localparam logic [3:0] c_sel_shr = 4'b1100;

    localparam logic [1:0] c_op_add = 2'b00;
    localparam logic [1:0] c_op_sub = 2'b01;
    localparam logic [1:0] c_op_mul = 2'b10;
    localparam logic [1:0] c_op_div = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXEC    = 3'd1,
        S_MUL     = 3'd2,
        S_DIV_CMP = 3'd3,
        S_DIV_SUB = 3'd4,
        S_DIV0    = 3'd5,
        S_DONE    = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : alu_seq_ctrl
// Desc   : Multi-cycle ADD/SUB/MUL/DIV sequencer driving a shared 8-bit ALU.
//          Optional macro ALU_SEQ_PERF_CNT_EN adds the alu_busy_cnt output.
// Rev    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result_hi,
    output logic [W-1:0] result_lo,
    output logic         div0,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_sel,
    input  logic [W-1:0] alu_out
`ifdef ALU_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]  alu_busy_cnt
`endif
);

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [1:0]   op_q, op_d;
    // hi/lo double as {product_hi, product_lo} for MUL and {rem, quo} for DIV
    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] lo_q, lo_d;
    logic         ge_q, ge_d;
    logic         div0_q, div0_d;

    logic [W-1:0] mul_s;
    logic         mul_c;
    logic [W-1:0] div_rsh;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'b00;
            hi_q    <= '0;
            lo_q    <= '0;
            ge_q    <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ge_q    <= ge_d;
            div0_q  <= div0_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        ge_d    = ge_q;
        div0_d  = div0_q;
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = c_sel_nop;
        mul_s   = hi_q;
        mul_c   = 1'b0;
        div_rsh = {hi_q[W-2:0], lo_q[W-1]};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d    = a_in;
                    b_d    = b_in;
                    op_d   = op;
                    div0_d = 1'b0;
                    cnt_d  = 4'd0;
                    case (op)
                        c_op_mul: begin
                            hi_d    = '0;
                            lo_d    = b_in;
                            state_d = S_MUL;
                        end
                        c_op_div: begin
                            if (b_in == '0) begin
                                state_d = S_DIV0;
                            end else begin
                                hi_d    = '0;
                                lo_d    = a_in;
                                state_d = S_DIV_CMP;
                            end
                        end
                        default: state_d = S_EXEC;
                    endcase
                end
            end

            S_EXEC: begin
                alu_a   = a_q;
                alu_b   = b_q;
                alu_sel = (op_q == c_op_add) ? c_sel_add : c_sel_sub;
                lo_d    = alu_out;
                hi_d    = {{(W-1){1'b0}},
                           (op_q == c_op_add) ? (alu_out < a_q) : (a_q < b_q)};
                state_d = S_DONE;
            end

            S_MUL: begin
                if (lo_q[0]) begin
                    alu_sel = c_sel_add;
                    alu_a   = hi_q;
                    alu_b   = a_q;
                    mul_s   = alu_out;
                    mul_c   = (alu_out < hi_q);
                end
                hi_d = {mul_c, mul_s[W-1:1]};
                lo_d = {mul_s[0], lo_q[W-1:1]};
                if (cnt_q == 4'd7) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            // Shifted remainder is committed here; the carried-out bit is folded into ge
            S_DIV_CMP: begin
                alu_sel = c_sel_lt;
                alu_a   = div_rsh;
                alu_b   = b_q;
                ge_d    = hi_q[W-1] | ~alu_out[0];
                hi_d    = div_rsh;
                lo_d    = {lo_q[W-2:0], 1'b0};
                state_d = S_DIV_SUB;
            end

            S_DIV_SUB: begin
                if (ge_q) begin
                    alu_sel = c_sel_sub;
                    alu_a   = hi_q;
                    alu_b   = b_q;
                    hi_d    = alu_out;
                    lo_d    = {lo_q[W-1:1], 1'b1};
                end
                if (cnt_q == 4'd7) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                    state_d = S_DIV_CMP;
                end
            end

            S_DIV0: begin
                lo_d    = '1;
                hi_d    = a_q;
                div0_d  = 1'b1;
                state_d = S_DONE;
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign result_hi = hi_q;
    assign result_lo = lo_q;
    assign div0      = div0_q;

`ifdef ALU_SEQ_PERF_CNT_EN
    logic [15:0] perf_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt_q <= 16'd0;
        end else if ((alu_sel != c_sel_nop) && (perf_cnt_q != 16'hFFFF)) begin
            perf_cnt_q <= perf_cnt_q + 16'd1;
        end
    end

    assign alu_busy_cnt = perf_cnt_q;
`endif

endmodule
`default_nettype wire
